wrr_arbiter: RTL and testbench
==============================

Name: wrr_arbiter

Overview:
- Weighted round-robin arbiter that shares one downstream resource among CLIENTS requesters.
- Once a client wins, it holds the grant for up to its programmed weight of unstalled cycles; priority then rotates to the next client.
- Sits in front of the shared datapath and uses the same stall back-pressure convention as the existing round-robin arbiter.
- Carries its own SVA assumptions and assertions: liveness bound, one-hot grant, stall freeze.

Parameters:
- CLIENTS, 8, number of requesters (2..32).
- WEIGHT_W, 4, width of each per-client weight field.
- IDX_W, $clog2(CLIENTS), width of client index fields (derived, not overridable).

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- request  input  CLIENTS  per-client request level; bit i belongs to client i.
- weight  input  CLIENTS*WEIGHT_W  per-client burst weight; client i uses bits [i*WEIGHT_W +: WEIGHT_W]; sampled only when client i wins.
- stall  input  1  downstream back-pressure; freezes all arbiter state.
- grant  output  CLIENTS  registered one-hot (or zero) grant.
- grant_id  output  IDX_W  index of granted client; 0 when grant==0.
- credit  output  WEIGHT_W  remaining unstalled cycles in the current burst, including the current cycle; 0 when idle.

Behaviour:
- Reset (sampled at posedge):
  - grant=0, grant_id=0, credit=0.
  - Rotation pointer ptr=0.
  - Reset overrides stall and request.
- Priority of updates at each posedge (not in reset), evaluated in this order:
  1. stall=1: grant, grant_id, credit, ptr all hold. No arbitration. A zero grant stays zero.
  2. Continue: grant!=0, request[grant_id]=1 and credit>1. Keep the grant; credit decrements by 1.
  3. Otherwise arbitrate:
     - Search request circularly starting at ptr: ptr, ptr+1, ..., wrapping modulo CLIENTS.
     - First set bit wins, i.e. grant=onehot(w), grant_id=w.
     - credit=weight[w], with a weight of 0 treated as 1.
     - ptr=(w+1) mod CLIENTS.
     - If no requests are set: grant=0, credit=0, ptr holds.
- Ends of a burst:
  - When a burst ends (credit reaches 1, or the granted client drops its request), ptr is already past the owner, so the owner has lowest priority.
  - The owner is re-granted back-to-back only if it is the sole requester. The re-grant loads a fresh weight.
- Timing:
  - Latency is one cycle: request set at cycle t with an idle arbiter gives grant at t+1.
  - There is no idle bubble between bursts: arbitration happens in the same edge that ends the previous burst.
- Request drop mid-burst: the grant is released at the next edge, regardless of remaining credit.
- Weight changes: a change in weight does not affect an in-flight burst. Weight is sampled only at the win.
- Invariants:
  - grant is one-hot or zero at all times.
  - grant[i] implies request[i] was high at the previous edge.
  - 1 <= credit <= max(weight,1) while granted.
- Fairness: a client holding request continuously is granted within (CLIENTS-1)*(2^WEIGHT_W-1)+1 unstalled cycles. Stalled cycles do not count toward this bound.
- ptr wrap: from CLIENTS-1, ptr goes to 0 with no skipped client.

Test Plan:
- Reset, then request=8'h01 and weight[0]=3 held high: grant=8'h01 from cycle 1; credit sequence 3,2,1,3 (re-grant as sole requester); grant never drops.
- request=8'h05 held, weight[0]=2, weight[2]=1: grant sequence 01,01,04,01,01,04.
- Client 3 granted with weight=5, then request[3] drops after 2 grant cycles: grant=0 (or the next requester) on the following edge, while credit is still 3.
- stall=1 for 4 cycles mid-burst (credit=2): grant, credit and ptr are frozen for exactly those cycles; the burst then completes with 2 more cycles.
- All 8 clients requesting with weights all 0: single-cycle rotation 01,02,04,...,80,01, confirming wrap at index 7.
- Reset asserted mid-burst together with stall=1: next cycle grant=0, credit=0. After release with request=8'h80, the first grant is 8'h80 (search from ptr=0 wraps to 7).

Source files
------------

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter.
// One client at a time owns the shared resource for a burst of up to its
// programmed weight of unstalled cycles. Priority then rotates to the client
// after the owner. Stall freezes every piece of arbiter state.
module wrr_arbiter #(
  parameter int CLIENTS  = 8,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W   = $clog2(CLIENTS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CLIENTS-1:0]           request,
  input  logic [CLIENTS*WEIGHT_W-1:0]  weight,
  input  logic                         stall,
  output logic [CLIENTS-1:0]           grant,
  output logic [IDX_W-1:0]             grant_id,
  output logic [WEIGHT_W-1:0]          credit
);

  logic [IDX_W-1:0]    ptr;
  logic                win_found;
  logic [IDX_W-1:0]    win_id;
  logic [CLIENTS-1:0]  win_onehot;
  logic [WEIGHT_W-1:0] win_w;
  logic [WEIGHT_W-1:0] win_credit;
  logic [IDX_W-1:0]    ptr_next;
  logic                keep;

  // The current owner keeps the grant while it still requests and has
  // more than one cycle of credit left.
  assign keep = (grant != '0) && request[grant_id] && (credit > WEIGHT_W'(1));

  // Circular first-set search starting at the rotation pointer.
  always_comb begin
    int idx;
    idx        = 0;
    win_found  = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= CLIENTS) idx = idx - CLIENTS;
      if (!win_found && request[idx]) begin
        win_found       = 1'b1;
        win_id          = IDX_W'(idx);
        win_onehot[idx] = 1'b1;
      end
    end
  end

  // Burst length of the winner (zero weight still yields one cycle) and the
  // pointer value that gives the winner lowest priority next time.
  always_comb begin
    win_w      = weight[int'(win_id)*WEIGHT_W +: WEIGHT_W];
    win_credit = (win_w == '0) ? WEIGHT_W'(1) : win_w;
    ptr_next   = (int'(win_id) == CLIENTS-1) ? '0 : IDX_W'(int'(win_id) + 1);
  end

  // Grant state: reset, freeze on stall, continue the burst, or re-arbitrate
  // in the same edge that ends the previous burst.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant    <= '0;
      grant_id <= '0;
      credit   <= '0;
      ptr      <= '0;
    end else if (!stall) begin
      if (keep) begin
        credit <= credit - WEIGHT_W'(1);
      end else if (win_found) begin
        grant    <= win_onehot;
        grant_id <= win_id;
        credit   <= win_credit;
        ptr      <= ptr_next;
      end else begin
        grant    <= '0;
        grant_id <= '0;
        credit   <= '0;
      end
    end
  end

`ifndef SYNTHESIS
  localparam int LIVE_BOUND = (CLIENTS-1)*((1 << WEIGHT_W)-1)+1;

  logic [31:0] wait_cnt [CLIENTS];

  // Unstalled cycles each client has spent requesting without holding a grant.
  always_ff @(posedge clock) begin
    for (int i = 0; i < CLIENTS; i++) begin
      if (reset || !request[i] || grant[i]) wait_cnt[i] <= '0;
      else if (!stall)                      wait_cnt[i] <= wait_cnt[i] + 32'd1;
    end
  end

  am_known: assume property (@(posedge clock) !$isunknown({reset, stall, request}));

  ap_onehot: assert property (@(posedge clock) $onehot0(grant));

  ap_idle: assert property (@(posedge clock)
    (grant == '0) |-> (grant_id == '0 && credit == '0));

  ap_credit: assert property (@(posedge clock)
    (grant != '0) |-> (credit != '0 && grant[grant_id]));

  ap_stall: assert property (@(posedge clock) disable iff (reset)
    stall |=> ($stable(grant) && $stable(grant_id) && $stable(credit) && $stable(ptr)));

  for (genvar g = 0; g < CLIENTS; g++) begin : g_live
    ap_live: assert property (@(posedge clock) disable iff (reset)
      wait_cnt[g] <= LIVE_BOUND);
  end
`endif

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: per-scenario stimulus tables; expected grant/credit
// pushed to a scoreboard when each cycle is driven, popped after the edge.
module tb_wrr_arbiter;
  localparam int CLIENTS  = 8;
  localparam int WEIGHT_W = 4;
  localparam int IDX_W    = 3;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        stall = 1'b0;
  logic [CLIENTS-1:0]          request = '0;
  logic [CLIENTS*WEIGHT_W-1:0] weight = '0;
  logic [CLIENTS-1:0]          grant;
  logic [IDX_W-1:0]            grant_id;
  logic [WEIGHT_W-1:0]         credit;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_g_q [$];
  logic [3:0] exp_c_q [$];

  always #5 clock = ~clock;

  wrr_arbiter #(.CLIENTS(CLIENTS), .WEIGHT_W(WEIGHT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .request  (request),
    .weight   (weight),
    .stall    (stall),
    .grant    (grant),
    .grant_id (grant_id),
    .credit   (credit)
  );

  function automatic logic [2:0] idx_of(input logic [7:0] oh);
    idx_of = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) idx_of = i[2:0];
  endfunction

  task automatic set_w(input int i, input logic [3:0] v);
    weight[i*WEIGHT_W +: WEIGHT_W] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; request = '0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] g; logic [3:0] c;
    logic       rs [3] = '{1'b1, 1'b1, 1'b0};
    logic       st [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] rq [3] = '{8'hff, 8'hff, 8'h00};
    weight = '1;
    for (int k = 0; k < 3; k++) begin
      reset = rs[k]; stall = st[k]; request = rq[k];
      exp_g_q.push_back(8'h00); exp_c_q.push_back(4'd0);
      @(posedge clock); #1;
      g = exp_g_q.pop_front(); c = exp_c_q.pop_front();
      total++;
      if (grant !== g || grant_id !== idx_of(g) || credit !== c) begin
        bad++;
        $display("FAIL reset[%0d]: got grant=%h id=%0d credit=%0d, want grant=%h id=%0d credit=%0d",
                 k, grant, grant_id, credit, g, idx_of(g), c);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] g; logic [3:0] c;
    logic [3:0] ec [6] = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1};
    do_reset();
    weight = '0; set_w(0, 4'd3);
    request = 8'h01;
    for (int k = 0; k < 6; k++) begin
      exp_g_q.push_back(8'h01); exp_c_q.push_back(ec[k]);
      @(posedge clock); #1;
      g = exp_g_q.pop_front(); c = exp_c_q.pop_front();
      total++;
      if (grant !== g || grant_id !== idx_of(g) || credit !== c) begin
        bad++;
        $display("FAIL single[%0d]: got grant=%h id=%0d credit=%0d, want grant=%h id=%0d credit=%0d",
                 k, grant, grant_id, credit, g, idx_of(g), c);
      end
    end
  endtask

  task automatic test_weighted();
    logic [7:0] g; logic [3:0] c;
    logic [7:0] eg [6] = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h01, 8'h04};
    logic [3:0] ec [6] = '{4'd2, 4'd1, 4'd1, 4'd2, 4'd1, 4'd1};
    do_reset();
    weight = '0; set_w(0, 4'd2); set_w(2, 4'd1);
    request = 8'h05;
    for (int k = 0; k < 6; k++) begin
      exp_g_q.push_back(eg[k]); exp_c_q.push_back(ec[k]);
      @(posedge clock); #1;
      g = exp_g_q.pop_front(); c = exp_c_q.pop_front();
      total++;
      if (grant !== g || grant_id !== idx_of(g) || credit !== c) begin
        bad++;
        $display("FAIL weighted[%0d]: got grant=%h id=%0d credit=%0d, want grant=%h id=%0d credit=%0d",
                 k, grant, grant_id, credit, g, idx_of(g), c);
      end
    end
  endtask

  task automatic test_drop();
    logic [7:0] g; logic [3:0] c;
    logic [7:0] rq [5] = '{8'h08, 8'h08, 8'h08, 8'h02, 8'h00};
    logic [7:0] eg [5] = '{8'h08, 8'h08, 8'h08, 8'h02, 8'h00};
    logic [3:0] ec [5] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd0};
    do_reset();
    weight = '0; set_w(3, 4'd5); set_w(1, 4'd2);
    for (int k = 0; k < 5; k++) begin
      request = rq[k];
      if (k == 1) set_w(3, 4'd1);
      exp_g_q.push_back(eg[k]); exp_c_q.push_back(ec[k]);
      @(posedge clock); #1;
      g = exp_g_q.pop_front(); c = exp_c_q.pop_front();
      total++;
      if (grant !== g || grant_id !== idx_of(g) || credit !== c) begin
        bad++;
        $display("FAIL drop[%0d]: got grant=%h id=%0d credit=%0d, want grant=%h id=%0d credit=%0d",
                 k, grant, grant_id, credit, g, idx_of(g), c);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] g; logic [3:0] c;
    logic       st [14] = '{0,0,0,1,1,1,1,0,0,0,0, 1,1,0};
    logic [7:0] rq [14] = '{8'h01,8'h01,8'h01,8'h03,8'h03,8'h03,8'h03,8'h03,8'h03,8'h03,8'h03,
                            8'hff,8'hff,8'hff};
    logic [7:0] eg [14] = '{8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h02,8'h02,8'h01,
                            8'h00,8'h00,8'h01};
    logic [3:0] ec [14] = '{4'd4,4'd3,4'd2,4'd2,4'd2,4'd2,4'd2,4'd1,4'd2,4'd1,4'd4,
                            4'd0,4'd0,4'd4};
    do_reset();
    weight = '0; set_w(0, 4'd4); set_w(1, 4'd2);
    for (int k = 0; k < 14; k++) begin
      if (k == 11) do_reset();
      stall = st[k]; request = rq[k];
      exp_g_q.push_back(eg[k]); exp_c_q.push_back(ec[k]);
      @(posedge clock); #1;
      g = exp_g_q.pop_front(); c = exp_c_q.pop_front();
      total++;
      if (grant !== g || grant_id !== idx_of(g) || credit !== c) begin
        bad++;
        $display("FAIL stall[%0d]: got grant=%h id=%0d credit=%0d, want grant=%h id=%0d credit=%0d",
                 k, grant, grant_id, credit, g, idx_of(g), c);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_rotate();
    logic [7:0] g; logic [3:0] c; logic [7:0] e;
    do_reset();
    weight = '0;
    request = 8'hff;
    for (int k = 0; k < 9; k++) begin
      e = 8'h01 << (k % 8);
      exp_g_q.push_back(e); exp_c_q.push_back(4'd1);
      @(posedge clock); #1;
      g = exp_g_q.pop_front(); c = exp_c_q.pop_front();
      total++;
      if (grant !== g || grant_id !== idx_of(g) || credit !== c) begin
        bad++;
        $display("FAIL rotate[%0d]: got grant=%h id=%0d credit=%0d, want grant=%h id=%0d credit=%0d",
                 k, grant, grant_id, credit, g, idx_of(g), c);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] g; logic [3:0] c;
    logic       rs [6] = '{0, 0, 1, 0, 0, 0};
    logic       st [6] = '{0, 0, 1, 0, 0, 0};
    logic [7:0] rq [6] = '{8'h04, 8'h04, 8'h04, 8'h80, 8'h80, 8'h80};
    logic [7:0] eg [6] = '{8'h04, 8'h04, 8'h00, 8'h80, 8'h80, 8'h80};
    logic [3:0] ec [6] = '{4'd5, 4'd4, 4'd0, 4'd2, 4'd1, 4'd2};
    do_reset();
    weight = '0; set_w(2, 4'd5); set_w(7, 4'd2);
    for (int k = 0; k < 6; k++) begin
      reset = rs[k]; stall = st[k]; request = rq[k];
      exp_g_q.push_back(eg[k]); exp_c_q.push_back(ec[k]);
      @(posedge clock); #1;
      g = exp_g_q.pop_front(); c = exp_c_q.pop_front();
      total++;
      if (grant !== g || grant_id !== idx_of(g) || credit !== c) begin
        bad++;
        $display("FAIL reset_mid[%0d]: got grant=%h id=%0d credit=%0d, want grant=%h id=%0d credit=%0d",
                 k, grant, grant_id, credit, g, idx_of(g), c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_weighted();
    test_drop();
    test_stall();
    test_rotate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
